apb_req_arbiter: RTL and testbench
==================================

Name: apb_req_arbiter

Overview:
- Shares the single APB master's internal request port (transfer/ready/addr/wdata/write/rdata) between NUM_REQ requesters, e.g. CPU and DMA.
- Arbitrates round-robin, latches the winner's command, fires one transfer pulse, waits for the master's ready, then returns read data and a done pulse to the winner.
- Sits between the requesters and the APB master; one transaction is outstanding at a time.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 255, WAIT-state cycle limit; used only with APB_ARB_TIMEOUT_EN.

Ports:
- PCLK  in  1  system clock, rising edge.
- PRESET  in  1  reset, synchronous, active-high.
- req  in  NUM_REQ  per-requester level request; held until that requester's done.
- req_addr  in  NUM_REQ*32  flattened addresses; slice i = [32*i+31:32*i].
- req_wdata  in  NUM_REQ*32  flattened write data.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- gnt  out  NUM_REQ  one-hot; high from ISSUE through DONE for the owner.
- done  out  NUM_REQ  one-hot, one-cycle completion pulse.
- err  out  NUM_REQ  one-cycle timeout flag, coincident with done.
- rdata  out  32  read data, broadcast; valid while done is high.
- busy  out  1  high in any state except IDLE.
- m_transfer  out  1  one-cycle start pulse to the master.
- m_addr  out  32  latched address.
- m_wdata  out  32  latched write data.
- m_write  out  1  latched direction.
- m_ready  in  1  master completion strobe (PREADY seen in ACCESS).
- m_rdata  in  32  master read data; valid with m_ready.

Behaviour:
Clocking and reset:
- One clock, PCLK. PRESET is synchronous and active-high.
- PRESET returns the block to IDLE: gnt=0, done=0, err=0, rdata=0, busy=0, m_transfer=0, m_addr/m_wdata=0, m_write=0, round-robin pointer last=NUM_REQ-1.
- Reset mid-transaction abandons it with no done pulse; the master shares PRESET.

States (enum in package): IDLE, ISSUE, WAIT, DONE.
- IDLE: if any req bit is high, pick the first set bit searching from (last+1) mod NUM_REQ upward with wrap. Latch idx plus that requester's addr, wdata and write into the m_* registers. Go to ISSUE. No req: stay.
- ISSUE: m_transfer=1 for exactly this cycle; gnt[idx]=1. Go to WAIT.
- WAIT: gnt[idx] held, m_* held stable. When m_ready=1, capture m_rdata into rdata if it was a read (writes leave rdata unchanged). Go to DONE.
- DONE: done[idx]=1 for one cycle; last<=idx. Go to IDLE.

Latency and handshake:
- Minimum req-to-done latency is 3 cycles plus the master's own latency (IDLE sample, ISSUE, WAIT of at least 1 cycle, DONE).
- A requester must drop req on the edge ending its done cycle; otherwise it is re-arbitrated as a new transaction.
- Deasserting req after grant does not abort; the transaction completes and done still pulses.
- A new request arriving during busy waits. Changes to req_addr/req_wdata after latching are ignored.

Boundary conditions:
- Simultaneous requests: the round-robin order guarantees each active requester is served within NUM_REQ transactions.
- Single requester: served back-to-back, with one IDLE cycle between transactions.
- m_ready outside WAIT is ignored.

Optional Feature:
- Macro: APB_ARB_TIMEOUT_EN.
- Defined: an 8..16-bit counter clears on entry to WAIT and increments each WAIT cycle. If it reaches TIMEOUT_CYCLES without m_ready, go to DONE with err[idx]=1, done[idx]=1 and rdata=32'h0.
- Not defined: no counter; err is tied to 0; WAIT lasts indefinitely.
- The port list is identical in both builds.

Decomposition:
- Package apb_arb_pkg: arb_state_e enum, APB_ADDR_W=32, APB_DATA_W=32, TIMEOUT_RDATA=32'h0.
- Sub-module apb_rr_pick, purely combinational: inputs req and last, outputs idx and a valid flag. It is reusable by other bus arbiters.

Test Plan:
- Single read, NUM_REQ=2: req[0]=1, addr=0x1000_0004, write=0; m_ready after 2 WAIT cycles with m_rdata=0xCAFE_0001 -> exactly one m_transfer pulse, m_addr=0x1000_0004, m_write=0; done[0] pulses with rdata=0xCAFE_0001; busy returns to 0.
- Single write: req[1]=1, addr=0x1000_0008, wdata=0x0000_00A5, write=1 -> m_wdata=0xA5, m_write=1, gnt=2'b10, done[1] one cycle; rdata unchanged.
- Contention: req=2'b11 held, each requester drops req after its own done -> grants in order 0,1; then re-assert both -> order 0,1 again; pointer verified as last=1 before the second round.
- Reset mid-WAIT: PRESET=1 for one cycle while in WAIT -> next cycle IDLE, all outputs 0, no done pulse, and the following grant goes to requester 0.
- Timeout (with APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4): m_ready never asserted -> after 4 WAIT cycles done[0]=1, err[0]=1, rdata=0. Without the macro: still in WAIT after 100 cycles and err=0.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB request arbiter and its round-robin picker.
package apb_arb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam logic [APB_DATA_W-1:0] TIMEOUT_RDATA = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        DONE  = 2'b11
    } arb_state_e;

endpackage

// File: rtl/apb_rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward from last+1 with wrap.
// Reusable by any requester arbiter; valid is low when no request is pending.
module apb_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    int              cand;
    logic [IDX_W-1:0] cand_idx;
    logic            hit;

    // Walk candidates last+1 .. last+NUM_REQ (mod NUM_REQ); the first hit wins.
    always_comb begin
        idx      = '0;
        valid    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        hit      = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand     = int'(last) + k;
            cand     = (cand >= NUM_REQ) ? (cand - NUM_REQ) : cand;
            cand_idx = IDX_W'(cand);
            hit      = req[cand_idx] && !valid;
            idx      = hit ? cand_idx : idx;
            valid    = valid || req[cand_idx];
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master request port between NUM_REQ requesters.
// Optional WAIT-state timeout is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*APB_ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*APB_DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]           req_write,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [NUM_REQ-1:0]           done,
    output logic [NUM_REQ-1:0]           err,
    output logic [APB_DATA_W-1:0]        rdata,
    output logic                         busy,
    output logic                         m_transfer,
    output logic [APB_ADDR_W-1:0]        m_addr,
    output logic [APB_DATA_W-1:0]        m_wdata,
    output logic                         m_write,
    input  logic                         m_ready,
    input  logic [APB_DATA_W-1:0]        m_rdata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("apb_req_arbiter: NUM_REQ or TIMEOUT_CYCLES out of range");
    end

    arb_state_e         state_r;
    arb_state_e         state_n;
    logic [IDX_W-1:0]   idx_r;
    logic [IDX_W-1:0]   last_r;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   owner_n;
    logic               pick_valid;
    logic               timeout_hit;
    logic [NUM_REQ-1:0] owner_onehot;

    function automatic logic [NUM_REQ-1:0] to_onehot(input logic [IDX_W-1:0] i);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    apb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req   (req),
        .last  (last_r),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // The owner for the coming cycle is the fresh pick when leaving IDLE, else the latched index.
    assign owner_n      = (state_r == IDLE) ? pick_idx : idx_r;
    assign owner_onehot = to_onehot(owner_n);

`ifdef APB_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wait_cnt_r;

    // WAIT-cycle counter, cleared in ISSUE so it starts at zero on entry to WAIT.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wait_cnt_r <= 16'd0;
        end else if (state_r == ISSUE) begin
            wait_cnt_r <= 16'd0;
        end else if (state_r == WAIT) begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    assign timeout_hit = (state_r == WAIT) && !m_ready && (wait_cnt_r == TIMEOUT_LAST);

    // Timeout flag is a one-cycle pulse aligned with the DONE state.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            err <= '0;
        end else begin
            err <= timeout_hit ? to_onehot(idx_r) : '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = '0;
`endif

    // Next-state logic for the single-outstanding-transaction FSM.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (pick_valid) begin
                    state_n = ISSUE;
                end else begin
                    state_n = IDLE;
                end
            end
            ISSUE: state_n = WAIT;
            WAIT: begin
                if (m_ready || timeout_hit) begin
                    state_n = DONE;
                end else begin
                    state_n = WAIT;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State, command latch and outputs; outputs are registered from the next state so they line up with it.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_r    <= IDLE;
            idx_r      <= '0;
            last_r     <= IDX_W'(NUM_REQ - 1);
            gnt        <= '0;
            done       <= '0;
            rdata      <= '0;
            busy       <= 1'b0;
            m_transfer <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_write    <= 1'b0;
        end else begin
            state_r    <= state_n;
            busy       <= (state_n != IDLE);
            m_transfer <= (state_n == ISSUE);
            gnt        <= (state_n != IDLE) ? owner_onehot : '0;
            done       <= (state_n == DONE) ? owner_onehot : '0;
            if (state_r == IDLE && pick_valid) begin
                idx_r   <= pick_idx;
                m_addr  <= req_addr[int'(pick_idx) * APB_ADDR_W +: APB_ADDR_W];
                m_wdata <= req_wdata[int'(pick_idx) * APB_DATA_W +: APB_DATA_W];
                m_write <= req_write[pick_idx];
            end
            // Writes leave rdata untouched; a timed-out transfer returns the fixed pattern.
            if (state_r == WAIT && m_ready && !m_write) begin
                rdata <= m_rdata;
            end else if (timeout_hit) begin
                rdata <= TIMEOUT_RDATA;
            end
            if (state_r == DONE) begin
                last_r <= idx_r;
            end
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Scoreboard bench for apb_req_arbiter: stimulus pushes expected transfers/completions,
// a monitor pops and compares them whenever m_transfer or done is presented.
module tb_apb_req_arbiter;

    localparam int N = 2;

    logic          PCLK;
    logic          PRESET;
    logic [N-1:0]  req;
    logic [N*32-1:0] req_addr;
    logic [N*32-1:0] req_wdata;
    logic [N-1:0]  req_write;
    logic [N-1:0]  gnt;
    logic [N-1:0]  done;
    logic [N-1:0]  err;
    logic [31:0]   rdata;
    logic          busy;
    logic          m_transfer;
    logic [31:0]   m_addr;
    logic [31:0]   m_wdata;
    logic          m_write;
    logic          m_ready;
    logic [31:0]   m_rdata;

    typedef struct { int idx; logic [31:0] addr; logic [31:0] wdata; logic wr; } xfer_t;
    typedef struct { int idx; logic [31:0] rdata; logic err; } done_t;
    typedef struct { int dly; logic [31:0] data; } resp_t;

    xfer_t xfer_q[$];
    done_t done_q[$];
    resp_t resp_q[$];
    logic [31:0] model_rdata;
    int tests;
    int failed;

    apb_req_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .req        (req),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_write  (req_write),
        .gnt        (gnt),
        .done       (done),
        .err        (err),
        .rdata      (rdata),
        .busy       (busy),
        .m_transfer (m_transfer),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_write    (m_write),
        .m_ready    (m_ready),
        .m_rdata    (m_rdata)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        tests++;
        failed++;
        $display("FAIL %s: event occurred, expected none", name);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_gnt"}, {30'd0, gnt}, 32'd0);
        check({tag, "_done"}, {30'd0, done}, 32'd0);
        check({tag, "_err"}, {30'd0, err}, 32'd0);
        check({tag, "_rdata"}, rdata, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_m_transfer"}, {31'd0, m_transfer}, 32'd0);
        check({tag, "_m_addr"}, m_addr, 32'd0);
        check({tag, "_m_wdata"}, m_wdata, 32'd0);
        check({tag, "_m_write"}, {31'd0, m_write}, 32'd0);
    endtask

    task automatic set_cmd(input int i, input logic [31:0] a, input logic [31:0] wd, input logic wr);
        req_addr[32*i +: 32]  = a;
        req_wdata[32*i +: 32] = wd;
        req_write[i]          = wr;
    endtask

    // Drive requester i's command and push the transfer, master response and completion it implies.
    task automatic expect_txn(input int i, input logic [31:0] a, input logic [31:0] wd, input logic wr,
                              input int dly, input logic [31:0] md);
        set_cmd(i, a, wd, wr);
        xfer_q.push_back('{i, a, wd, wr});
        resp_q.push_back('{dly, md});
        if (!wr) model_rdata = md;
        done_q.push_back('{i, model_rdata, 1'b0});
    endtask

    task automatic drain(input string name, input int budget);
        int  n;
        logic fin;
        n   = 0;
        fin = 1'b0;
        while (!fin && n < budget) begin
            @(negedge PCLK);
            req = req & ~done;
            if (done_q.size() == 0 && xfer_q.size() == 0 && !busy && req == '0) fin = 1'b1;
            n++;
        end
        if (!fin) begin
            tests++;
            failed++;
            $display("FAIL %s: not drained within %0d cycles", name, budget);
        end
    endtask

    // Master model: answers each transfer after the queued number of WAIT cycles.
    initial begin
        resp_t r;
        m_ready = 1'b0;
        m_rdata = 32'd0;
        forever begin
            @(negedge PCLK);
            m_ready = 1'b0;
            if (m_transfer && !PRESET && resp_q.size() > 0) begin
                r = resp_q.pop_front();
                repeat (r.dly) @(negedge PCLK);
                m_ready = 1'b1;
                m_rdata = r.data;
            end
        end
    end

    // Monitor: compares presented transfers and completions against the scoreboard.
    initial begin
        logic  prev_xfer;
        xfer_t x;
        done_t d;
        prev_xfer = 1'b0;
        forever begin
            @(negedge PCLK);
            if (PRESET) begin
                prev_xfer = 1'b0;
            end else begin
                if (m_transfer) begin
                    check("xfer_single_pulse", {31'd0, prev_xfer}, 32'd0);
                    if (xfer_q.size() == 0) begin
                        note_fail("xfer_unexpected");
                    end else begin
                        x = xfer_q.pop_front();
                        check("xfer_gnt", {30'd0, gnt}, 32'd1 << x.idx);
                        check("xfer_m_addr", m_addr, x.addr);
                        check("xfer_m_wdata", m_wdata, x.wdata);
                        check("xfer_m_write", {31'd0, m_write}, {31'd0, x.wr});
                    end
                end
                prev_xfer = m_transfer;
                if (done != '0) begin
                    if (done_q.size() == 0) begin
                        note_fail("done_unexpected");
                    end else begin
                        d = done_q.pop_front();
                        check("done_onehot", {30'd0, done}, 32'd1 << d.idx);
                        check("done_gnt", {30'd0, gnt}, 32'd1 << d.idx);
                        check("done_rdata", rdata, d.rdata);
                        check("done_err", {30'd0, err}, d.err ? (32'd1 << d.idx) : 32'd0);
                    end
                end
            end
        end
    end

    initial begin
        int   lat;
        logic seen;
        tests       = 0;
        failed      = 0;
        model_rdata = 32'd0;
        PRESET      = 1'b1;
        req         = '0;
        req_addr    = '0;
        req_wdata   = '0;
        req_write   = '0;
        repeat (3) @(negedge PCLK);
        check_idle("reset");
        PRESET = 1'b0;

        // Single read with two WAIT cycles: done expected on the 4th cycle.
        expect_txn(0, 32'h1000_0004, 32'h0000_0000, 1'b0, 2, 32'hCAFE_0001);
        req[0] = 1'b1;
        lat = 0;
        do begin
            @(negedge PCLK);
            lat++;
        end while (done[0] !== 1'b1 && lat < 20);
        check("read_latency", lat, 32'd4);
        req[0] = 1'b0;
        @(negedge PCLK);
        check("read_done_one_cycle", {30'd0, done}, 32'd0);
        check("read_busy_cleared", {31'd0, busy}, 32'd0);

        // Single write: master data must not reach rdata.
        expect_txn(1, 32'h1000_0008, 32'h0000_00A5, 1'b1, 1, 32'hDEAD_BEEF);
        req[1] = 1'b1;
        drain("write", 40);
        check("write_rdata_kept", rdata, 32'hCAFE_0001);

        // Contention after last=1: order 0 then 1, twice.
        expect_txn(0, 32'h2000_0000, 32'h0000_0000, 1'b0, 1, 32'h1111_0000);
        expect_txn(1, 32'h2000_0100, 32'h0000_0000, 1'b0, 3, 32'h2222_0001);
        req = 2'b11;
        drain("contention1", 60);
        check("last_ptr_after_round1", {31'd0, dut.last_r}, 32'd1);
        expect_txn(0, 32'h2000_0004, 32'h5A5A_0000, 1'b1, 2, 32'h0000_0000);
        expect_txn(1, 32'h2000_0104, 32'h0000_0000, 1'b0, 1, 32'h3333_0002);
        req = 2'b11;
        drain("contention2", 60);

        // After requester 0 is served alone, contention must favour requester 1.
        expect_txn(0, 32'h4000_0000, 32'h0000_0000, 1'b0, 1, 32'h4444_0000);
        req[0] = 1'b1;
        drain("single0", 40);
        expect_txn(1, 32'h4000_0100, 32'h0000_0000, 1'b0, 1, 32'h5555_0001);
        expect_txn(0, 32'h4000_0004, 32'h0F0F_0F0F, 1'b1, 1, 32'h0000_0000);
        req = 2'b11;
        drain("contention_rr", 60);

        // Reset in WAIT: no completion, outputs cleared, pointer back to NUM_REQ-1.
        set_cmd(1, 32'h3000_0000, 32'h0000_0077, 1'b0);
        xfer_q.push_back('{1, 32'h3000_0000, 32'h0000_0077, 1'b0});
        req = 2'b10;
        repeat (3) @(negedge PCLK);
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        check("pre_reset_gnt", {30'd0, gnt}, 32'd2);
        PRESET = 1'b1;
        req    = '0;
        @(negedge PCLK);
        PRESET = 1'b0;
        check_idle("mid_wait_reset");
        repeat (3) @(negedge PCLK);
        check("post_reset_idle", {31'd0, busy}, 32'd0);
        model_rdata = 32'd0;
        expect_txn(0, 32'h3000_0010, 32'h0000_0000, 1'b0, 1, 32'h6666_0000);
        expect_txn(1, 32'h3000_0110, 32'h0000_0000, 1'b0, 1, 32'h7777_0001);
        req = 2'b11;
        drain("post_reset", 60);

`ifdef APB_ARB_TIMEOUT_EN
        // No master response: four WAIT cycles, then done with err and zero data.
        set_cmd(0, 32'h5000_0000, 32'h0000_0000, 1'b0);
        xfer_q.push_back('{0, 32'h5000_0000, 32'h0000_0000, 1'b0});
        model_rdata = 32'd0;
        done_q.push_back('{0, 32'h0000_0000, 1'b1});
        req[0] = 1'b1;
        lat = 0;
        do begin
            @(negedge PCLK);
            lat++;
        end while (done[0] !== 1'b1 && lat < 40);
        check("timeout_latency", lat, 32'd6);
        req[0] = 1'b0;
        drain("timeout", 20);
`else
        // No master response and no timeout: the transaction waits indefinitely.
        set_cmd(0, 32'h5000_0000, 32'h0000_0000, 1'b0);
        xfer_q.push_back('{0, 32'h5000_0000, 32'h0000_0000, 1'b0});
        req[0] = 1'b1;
        seen = 1'b0;
        repeat (100) begin
            @(negedge PCLK);
            if (done != '0 || err != '0) seen = 1'b1;
        end
        check("no_timeout_busy", {31'd0, busy}, 32'd1);
        check("no_timeout_gnt", {30'd0, gnt}, 32'd1);
        check("no_timeout_err", {30'd0, err}, 32'd0);
        check("no_timeout_no_done", {31'd0, seen}, 32'd0);
        PRESET = 1'b1;
        req    = '0;
        @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);
        check("no_timeout_reset_idle", {31'd0, busy}, 32'd0);
`endif

        repeat (2) @(negedge PCLK);
        check("scoreboard_empty", xfer_q.size() + done_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
